// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequential Booth multiply / restoring divide sequencer driving a shared 32-bit add/sub unit.
// Divide support is built only when MULTDIV_CTRL_DIV_EN is defined; otherwise ctrl_DIV reports an exception.
module multdiv_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] add_A,
   output logic [31:0] add_B,
   output logic        add_subTrue,
   input  logic [31:0] add_S,
   input  logic        add_overflow,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);
`ifdef MULTDIV_CTRL_DIV_EN
   typedef enum logic [2:0] {IDLE, MUL_ITER, DIV_ABS_A, DIV_ABS_B, DIV_ITER, DIV_SIGN, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, MUL_ITER, DONE} state_t;
`endif
   state_t state, nextState;
   logic [4:0]  count;
   logic [31:0] opA, hi, lo;
   logic        q, isDiv;
   logic        start, mulSign, mulExc;
   assign start   = ctrl_MULT | ctrl_DIV;
   // sign of the true sum, valid even when the 32-bit add overflowed
   assign mulSign = add_S[31] ^ add_overflow;
   assign mulExc  = hi != {32{lo[31]}};
`ifdef MULTDIV_CTRL_DIV_EN
   logic [31:0] opB, divMag, remShift;
   logic        borrow, divExc;
   assign remShift = {hi[30:0], lo[31]};
   // unsigned compare from a signed subtractor: differing MSBs decide directly
   assign borrow   = (remShift[31] != divMag[31]) ? divMag[31] : add_S[31];
   assign divExc   = (opB == 32'd0) || (opA == 32'h8000_0000 && opB == 32'hFFFF_FFFF);
`endif
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= IDLE;
      else state <= nextState;
   always_comb begin
      nextState   = state;
      add_A       = '0;
      add_B       = '0;
      add_subTrue = 1'b0;
      case (state)
         MUL_ITER: begin
            add_A       = hi;
            add_B       = (lo[0] ^ q) ? opA : '0;
            add_subTrue = lo[0] & ~q;
            nextState   = (count == 5'd31) ? DONE : MUL_ITER;
         end
`ifdef MULTDIV_CTRL_DIV_EN
         DIV_ABS_A: begin
            add_B       = opA;
            add_subTrue = 1'b1;
            nextState   = DIV_ABS_B;
         end
         DIV_ABS_B: begin
            add_B       = opB;
            add_subTrue = 1'b1;
            nextState   = DIV_ITER;
         end
         DIV_ITER: begin
            add_A       = remShift;
            add_B       = divMag;
            add_subTrue = 1'b1;
            nextState   = (count == 5'd31) ? DIV_SIGN : DIV_ITER;
         end
         DIV_SIGN: begin
            add_B       = lo;
            add_subTrue = 1'b1;
            nextState   = DONE;
         end
`endif
         DONE:    nextState = IDLE;
         default: nextState = state;
      endcase
`ifdef MULTDIV_CTRL_DIV_EN
      if (start) nextState = ctrl_MULT ? MUL_ITER : DIV_ABS_A;
`else
      if (start) nextState = ctrl_MULT ? MUL_ITER : DONE;
`endif
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count          <= '0;
         opA            <= '0;
         hi             <= '0;
         lo             <= '0;
         q              <= 1'b0;
         isDiv          <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
`ifdef MULTDIV_CTRL_DIV_EN
         opB            <= '0;
         divMag         <= '0;
`endif
      end else begin
         data_resultRDY <= 1'b0;
         if (start) begin
            count          <= '0;
            opA            <= data_operandA;
            hi             <= '0;
            lo             <= data_operandB;
            q              <= 1'b0;
            isDiv          <= ~ctrl_MULT;
            data_result    <= '0;
            data_exception <= 1'b0;
`ifdef MULTDIV_CTRL_DIV_EN
            opB            <= data_operandB;
`endif
         end else begin
            case (state)
               MUL_ITER: begin
                  hi    <= {mulSign, add_S[31:1]};
                  lo    <= {add_S[0], lo[31:1]};
                  q     <= lo[0];
                  count <= count + 5'd1;
               end
`ifdef MULTDIV_CTRL_DIV_EN
               DIV_ABS_A: lo <= opA[31] ? add_S : opA;
               DIV_ABS_B: divMag <= opB[31] ? add_S : opB;
               DIV_ITER: begin
                  hi    <= borrow ? remShift : add_S;
                  lo    <= {lo[30:0], ~borrow};
                  count <= count + 5'd1;
               end
               DIV_SIGN: begin
                  data_result    <= divExc ? '0 : ((opA[31] ^ opB[31]) ? add_S : lo);
                  data_exception <= divExc;
                  data_resultRDY <= 1'b1;
               end
               DONE: if (!isDiv) begin
                  data_result    <= lo;
                  data_exception <= mulExc;
                  data_resultRDY <= 1'b1;
               end
`else
               DONE: begin
                  data_result    <= isDiv ? '0 : lo;
                  data_exception <= isDiv | mulExc;
                  data_resultRDY <= 1'b1;
               end
`endif
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed scoreboard bench for multdiv_ctrl with a behavioural model of the shared add/sub unit.
module tb_multdiv_ctrl;
   logic        clock = 1'b0, reset = 1'b1;
   logic [31:0] data_operandA = '0, data_operandB = '0;
   logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
   logic [31:0] add_A, add_B, add_S, data_result;
   logic        add_subTrue, add_overflow, data_exception, data_resultRDY;

   multdiv_ctrl dut (
      .clock(clock), .reset(reset),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .add_A(add_A), .add_B(add_B), .add_subTrue(add_subTrue),
      .add_S(add_S), .add_overflow(add_overflow),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY)
   );

   always #5 clock = ~clock;

   assign add_S        = add_subTrue ? add_A - add_B : add_A + add_B;
   assign add_overflow = (add_A[31] == (add_B[31] ^ add_subTrue)) && (add_S[31] != add_A[31]);

   typedef struct {logic [31:0] r; logic e; int lat;} exp_t;
   exp_t sb[$];
   int errs = 0, checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errs++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
      end
   endtask

   task automatic pushMul(input logic [31:0] a, input logic [31:0] b);
      exp_t x;
      longint p;
      p = longint'(signed'(a)) * longint'(signed'(b));
      x.r = p[31:0];
      x.e = p[63:31] != {33{p[31]}};
      x.lat = 33;
      sb.push_back(x);
   endtask

   task automatic pushDiv(input logic [31:0] a, input logic [31:0] b);
      exp_t x;
`ifdef MULTDIV_CTRL_DIV_EN
      x.lat = 35;
      if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
         x.r = '0;
         x.e = 1'b1;
      end else begin
         x.r = $signed(a) / $signed(b);
         x.e = 1'b0;
      end
`else
      x.lat = 1;
      x.r = '0;
      x.e = 1'b1;
`endif
      sb.push_back(x);
   endtask

   task automatic drive(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT = m;
      ctrl_DIV = d;
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
   endtask

   task automatic collect(input string tag);
      exp_t x;
      int lat;
      lat = -1;
      x = sb.pop_front();
      for (int k = 1; k <= 60; k++) begin
         @(negedge clock);
         if (data_resultRDY) begin
            lat = k;
            break;
         end
      end
      chk({tag, ".latency"}, lat, x.lat);
      if (lat >= 0) begin
         chk({tag, ".result"}, data_result, x.r);
         chk({tag, ".exception"}, {31'd0, data_exception}, {31'd0, x.e});
         @(negedge clock);
         chk({tag, ".rdyPulse"}, {31'd0, data_resultRDY}, 32'd0);
         chk({tag, ".hold"}, data_result, x.r);
      end
   endtask

   task automatic run(input bit m, input logic [31:0] a, input logic [31:0] b, input string tag);
      if (m) pushMul(a, b);
      else pushDiv(a, b);
      drive(m, ~m, a, b);
      collect(tag);
   endtask

   task automatic checkIdleOutputs(input string tag);
      chk({tag, ".result"}, data_result, 32'd0);
      chk({tag, ".exception"}, {31'd0, data_exception}, 32'd0);
      chk({tag, ".rdy"}, {31'd0, data_resultRDY}, 32'd0);
      chk({tag, ".addA"}, add_A, 32'd0);
      chk({tag, ".addB"}, add_B, 32'd0);
      chk({tag, ".sub"}, {31'd0, add_subTrue}, 32'd0);
   endtask

   initial begin
      int extra;
      repeat (2) @(negedge clock);
      checkIdleOutputs("reset");
      reset = 1'b0;
      run(1'b1, 32'd7, 32'hFFFF_FFFA, "mul7xm6");
      run(1'b1, 32'h7FFF_FFFF, 32'd2, "mulOvf");
      run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "mulMinXm1");
      run(1'b1, 32'hFFFF_CFC7, 32'd6789, "mulNegPos");
      run(1'b1, 32'h8000_0000, 32'h8000_0000, "mulMinXMin");
      run(1'b1, 32'd0, 32'd5, "mulZero");
      run(1'b0, 32'hFFFF_FFF9, 32'd2, "divm7x2");
      run(1'b0, 32'h8000_0000, 32'd1, "divMinX1");
      run(1'b0, 32'd5, 32'd0, "divByZero");
      run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divMinXm1");
      run(1'b0, 32'd100, 32'hFFFF_FFF9, "div100xm7");
      run(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, "divm1xMin");
      run(1'b0, 32'h7FFF_FFFF, 32'd3, "divMaxX3");
      pushMul(32'd11, 32'hFFFF_FFFD);
      drive(1'b1, 1'b1, 32'd11, 32'hFFFF_FFFD);
      collect("bothStarts");
      drive(1'b1, 1'b0, 32'd5, 32'd5);
      repeat (9) @(negedge clock);
      run(1'b0, 32'd100, 32'd7, "abortDiv");
      extra = 0;
      repeat (40) begin
         @(negedge clock);
         if (data_resultRDY) extra++;
      end
      chk("abort.noMulRdy", extra, 32'd0);
`ifdef MULTDIV_CTRL_DIV_EN
      drive(1'b0, 1'b1, 32'd1000, 32'd3);
`else
      drive(1'b1, 1'b0, 32'd1000, 32'd3);
`endif
      repeat (19) @(negedge clock);
      reset = 1'b1;
      #1;
      checkIdleOutputs("midReset");
      @(negedge clock);
      reset = 1'b0;
      extra = 0;
      repeat (50) begin
         @(negedge clock);
         if (data_resultRDY) extra++;
      end
      chk("midReset.noRdy", extra, 32'd0);
      run(1'b1, 32'd3, 32'd3, "mul3x3");
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: clock  in  1  sole clock, rising edge.
REQ-002 reset  in  1  asynchronous, active-high; the block has one clock and this asynchronous active-high reset.
REQ-003 data_operandA  in  32  signed multiplicand / dividend.
REQ-004 data_operandB  in  32  signed multiplier / divisor.
REQ-005 ctrl_MULT  in  1  start-multiply pulse; ctrl_DIV  in  1  start-divide pulse.
REQ-006 add_A, add_B  out  32  operands driven to the shared 32-bit add/sub unit.
REQ-007 add_subTrue  out  1  selects subtract (A-B) on the shared unit.
REQ-008 add_S  in  32  sum from the shared unit; add_overflow  in  1  its signed overflow flag.
REQ-009 data_result  out  32  product low word / quotient.
REQ-010 data_exception  out  1  overflow or divide-by-zero.
REQ-011 data_resultRDY  out  1  one-cycle completion strobe.

Function
REQ-012 SHALL have states IDLE, MUL_ITER, DIV_ABS_A, DIV_ABS_B, DIV_ITER, DIV_SIGN, DONE, and a 5-bit iteration counter.
REQ-013 SHALL sample ctrl_MULT/ctrl_DIV and latch both operands on every rising edge in any state; a start aborts any operation in progress and restarts.
REQ-014 SHALL give ctrl_MULT priority when both starts are high in the same cycle.
REQ-015 Multiply: radix-2 Booth; init hi=0, lo=operandB, q=0; per MUL_ITER cycle, {lo[0],q}=01 -> hi+A, 10 -> hi-A, else hi+0 (add_B=0, add_subTrue=0).
REQ-016 After each multiply add, SHALL arithmetic-shift {S,lo,q} right by 1, with the shifted-in sign equal to add_S[31] XOR add_overflow.
REQ-017 Multiply runs 32 MUL_ITER cycles; data_exception=1 if hi is not all copies of lo[31]; data_result=lo.
REQ-018 Divide: DIV_ABS_A drives 0-A (negate only if A[31]) to form |A|; DIV_ABS_B does the same for |B|; magnitudes are unsigned 32-bit (0x80000000 legal).
REQ-019 DIV_ITER: 32 restoring steps; R'={R[30:0],Q[31]}; trial R'-|B| on the shared unit; unsigned borrow = (R'[31]!=|B|[31]) ? |B|[31] : add_S[31]; no borrow -> R=S, Q bit=1, else R=R', Q bit=0.
REQ-020 DIV_SIGN negates Q through the shared unit when A[31]!=B[31].
REQ-021 Divide exception, result 0: divisor zero, or operandA=0x80000000 with operandB=0xFFFFFFFF.
REQ-022 Multiply exception still presents lo on data_result.
REQ-023 Latency: data_resultRDY high exactly 33 cycles (multiply) / 35 cycles (divide) after the edge that sampled the start, for one cycle, then IDLE.
REQ-024 data_result/data_exception SHALL hold their value from DONE until the next start edge.
REQ-025 In IDLE and DONE, add_A=add_B=0 and add_subTrue=0.

Reset
REQ-026 On reset: state IDLE, counter 0, data_result=0, data_exception=0, data_resultRDY=0, adder outputs 0; asserting mid-operation abandons it with no RDY strobe.

Configuration
REQ-027 Macro MULTDIV_CTRL_DIV_EN defined: divide supported as specified.
REQ-028 MULTDIV_CTRL_DIV_EN undefined: DIV_* states omitted; ctrl_DIV yields data_exception=1, data_result=0, data_resultRDY one cycle after the start edge; multiply unchanged.

Verification
REQ-029 A=7, B=-6, ctrl_MULT -> RDY at cycle 33, result 0xFFFFFFD6, exception 0.
REQ-030 A=0x7FFFFFFF, B=2 multiply -> result 0xFFFFFFFE, exception 1; A=0x80000000, B=-1 -> exception 1.
REQ-031 A=-7, B=2, ctrl_DIV -> RDY at cycle 35, result 0xFFFFFFFD; A=0x80000000, B=1 -> 0x80000000, exception 0.
REQ-032 Divide by B=0 -> result 0, exception 1; A=0x80000000, B=-1 -> result 0, exception 1.
REQ-033 Both starts high together -> multiply runs, RDY at 33; ctrl_DIV at cycle 10 of a multiply -> only divide RDY, 35 cycles after the restart.
REQ-034 reset at cycle 20 of a divide -> all outputs 0, no RDY; a following multiply of 3*3 -> 9 at cycle 33.
